// File: rtl/scan_code_gen_pkg.sv
// Shared sizing and types for the slot-scan sequencer and its downstream decoder.
package scan_code_gen_pkg;

  localparam int NUM_SLOTS   = 4;
  localparam int CODE_W      = 2;
  localparam int DEFAULT_DIV = 4;

  typedef logic [CODE_W-1:0] code_t;

  // Result of the next-slot search: found is low when no mask bit is set.
  typedef struct packed {
    logic  found;
    code_t code;
  } pick_t;

endpackage

// File: rtl/scan_prescaler.sv
// Free-running divide-by-DIV counter with synchronous clear and terminal-count pulse.
module scan_prescaler #(
  parameter int DIV = 4,
  parameter int PW  = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tc
);

  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  // tc is gated by clr so a stale count left when scanning stops never fires a step.
  assign tc = !clr && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + PW'(1);
    if (clr || tc) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scan_code_gen.sv
// Steps a 2-bit slot code through the mask-enabled slots at a prescaled rate,
// flagging each step (tick) and the start of each scan pass (frame).
module scan_code_gen
  import scan_code_gen_pkg::*;
#(
  parameter int DIV = DEFAULT_DIV,
  parameter int PW  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NUM_SLOTS-1:0] mask,
  output logic [CODE_W-1:0]    code,
  output logic                 code_valid,
  output logic                 tick,
  output logic                 frame
);

  logic  step;
  code_t code_q, code_d;
  logic  code_valid_q, code_valid_d;
  logic  tick_q, tick_d;
  logic  frame_q, frame_d;
  logic  first_q, first_d;
  pick_t pick;

  // A fresh run searches from slot 0; otherwise the current slot is tried last.
  function automatic pick_t next_slot(input logic [NUM_SLOTS-1:0] m,
                                      input code_t cur, input logic from_start);
    pick_t r;
    code_t cand;
    r = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      cand = from_start ? code_t'(i) : code_t'(cur + code_t'(i + 1));
      if (!r.found && m[cand]) begin
        r.found = 1'b1;
        r.code  = cand;
      end
    end
    return r;
  endfunction

  scan_prescaler #(
    .DIV (DIV),
    .PW  (PW)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!en),
    .tc    (step)
  );

  always_comb begin
    pick    = next_slot(mask, code_q, first_q);
    code_d  = code_q;
    first_d = first_q;
    tick_d  = 1'b0;
    frame_d = 1'b0;
    if (!en) begin
      first_d = 1'b1;
    end else if (step && pick.found) begin
      code_d  = pick.code;
      tick_d  = 1'b1;
      // Landing at or below the old slot means the pass wrapped (incl. single-slot).
      frame_d = first_q || (pick.code <= code_q);
      first_d = 1'b0;
    end
    code_valid_d = en && mask[code_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q       <= '0;
      code_valid_q <= 1'b0;
      tick_q       <= 1'b0;
      frame_q      <= 1'b0;
      first_q      <= 1'b1;
    end else begin
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      tick_q       <= tick_d;
      frame_q      <= frame_d;
      first_q      <= first_d;
    end
  end

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign tick       = tick_q;
  assign frame      = frame_q;

endmodule
